// File: rtl/hex_sequence_player.sv
// Programmable hex-digit sequence player: stores up to DEPTH digits, steps through them with wrap-around
// and shows a NUM_DIGITS sliding window on active-low seven-segment outputs. Define SEQ_AUTOPLAY_EN for timed autoplay.
module hex_sequence_player #(
    parameter  int DEPTH      = 8,
    parameter  int NUM_DIGITS = 2,
    parameter  int TICK_DIV   = 50000000,
    localparam int LW         = $clog2(DEPTH + 1),
    localparam int PW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load_valid,
    input  logic [3:0]              load_digit,
    output logic                    load_ready,
    input  logic                    step,
    input  logic                    dir,
    input  logic                    play,
    output logic [LW-1:0]           len,
    output logic [PW-1:0]           pos,
    output logic                    empty,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int SW = LW + 1;

    typedef enum logic {S_EMPTY, S_SHOW} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            step_q;
    logic            step_edge;
    logic            advance;
    logic            load_acc;
    logic            wr_en;
    logic [3:0]      mem [DEPTH];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign load_ready = (len_q < LW'(DEPTH));
    assign empty      = (len_q == '0);
    assign len        = len_q;
    assign pos        = pos_q;
    assign step_edge  = step && !step_q;
    assign load_acc   = load_valid && load_ready && !clear;

`ifdef SEQ_AUTOPLAY_EN
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick    = play && !empty && (tick_cnt == CW'(TICK_DIV - 1));
    // A manual edge coinciding with a tick still yields a single advance.
    assign advance = step_edge || tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (!play || empty || clear || step_edge || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end
`else
    localparam int unused_tick_div = TICK_DIV;
    logic unused_play;

    assign unused_play = play;
    assign advance     = step_edge;
`endif

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        wr_en   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (load_acc) begin
                    wr_en   = 1'b1;
                    len_d   = len_q + LW'(1);
                    state_d = S_SHOW;
                end
            end
            default: begin
                if (clear) begin
                    len_d   = '0;
                    pos_d   = '0;
                    state_d = S_EMPTY;
                end else begin
                    // Advance wraps against the pre-load length.
                    if (advance && len_q != '0) begin
                        if (dir) begin
                            pos_d = (LW'(pos_q) == len_q - LW'(1)) ? '0 : pos_q + PW'(1);
                        end else begin
                            pos_d = (pos_q == '0) ? PW'(len_q - LW'(1)) : pos_q - PW'(1);
                        end
                    end
                    if (load_acc) begin
                        wr_en = 1'b1;
                        len_d = len_q + LW'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            len_q   <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            step_q  <= step;
        end
    end

    // NOTE: the digit array has no reset; entries at or beyond len are never displayed.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[len_q[PW-1:0]] <= load_digit;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [SW-1:0] raw_idx;
        logic [SW-1:0] wrap_idx;
        logic          blank;

        // pos < len and k < len whenever shown, so one conditional subtract is the modulo.
        assign raw_idx  = SW'(pos_q) + SW'(k);
        assign wrap_idx = (raw_idx >= SW'(len_q)) ? raw_idx - SW'(len_q) : raw_idx;
        assign blank    = (state_q == S_EMPTY) || (LW'(k) >= len_q);
        assign hex[7*k +: 7] = blank ? 7'b1111111 : seg7(mem[wrap_idx[PW-1:0]]);
    end

endmodule
